// File: rtl/vslc_servo_pkg.sv
// Shared definitions for the vslc servo controller.
//   - config register addresses and ctrl register bit positions
//   - timing_t: one complete timing set, used for both the shadow copy
//     (written by the bus) and the active copy (seen by the channel)
//   - commit FSM state encoding
//   - apply_write(): byte-lane write of one register into a timing set
package vslc_servo_pkg;

  localparam logic [2:0] ADDR_SET     = 3'd0;
  localparam logic [2:0] ADDR_RESET   = 3'd1;
  localparam logic [2:0] ADDR_FREQ_LO = 3'd2;
  localparam logic [2:0] ADDR_FREQ_HI = 3'd3;
  localparam logic [2:0] ADDR_PRE_LO  = 3'd4;
  localparam logic [2:0] ADDR_PRE_HI  = 3'd5;
  localparam logic [2:0] ADDR_CTRL    = 3'd6;
  localparam logic [2:0] ADDR_RSVD    = 3'd7;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_COMMIT = 1;

  typedef struct packed {
    logic [7:0]  set_val;
    logic [7:0]  reset_val;
    logic [15:0] freq;
    logic [15:0] prescale;
  } timing_t;

  typedef enum logic {
    COMMIT_IDLE    = 1'b0,
    COMMIT_PENDING = 1'b1
  } commit_state_e;

  // Returns cur with the register at addr replaced by data. Ctrl and
  // reserved addresses leave the timing set untouched.
  function automatic timing_t apply_write(input timing_t    cur,
                                          input logic [2:0] addr,
                                          input logic [7:0] data);
    timing_t nxt;
    nxt = cur;
    case (addr)
      ADDR_SET:     nxt.set_val        = data;
      ADDR_RESET:   nxt.reset_val      = data;
      ADDR_FREQ_LO: nxt.freq[7:0]      = data;
      ADDR_FREQ_HI: nxt.freq[15:8]     = data;
      ADDR_PRE_LO:  nxt.prescale[7:0]  = data;
      ADDR_PRE_HI:  nxt.prescale[15:8] = data;
      default:      nxt                = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vslc_servo_prescaler.sv
// Servo tick prescaler.
// Counts 0..P with P = max(prescale, 1) while run is high. On the clock
// edge where the count reaches P the count returns to 0 and tick goes high
// for exactly the following cycle. The clamp to 1 guarantees tick is never
// high on two consecutive cycles.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         count while high; held cleared while low
//   clear       synchronous clear of count and tick
//   prescale    terminal count (0 treated as 1)
//   tick        registered one-cycle tick
module vslc_servo_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        clear,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] count;
  logic [15:0] limit;

  assign limit = (prescale == 16'd0) ? 16'd1 : prescale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
      tick  <= 1'b0;
    end else if (clear || !run) begin
      count <= 16'd0;
      tick  <= 1'b0;
    end else if (count >= limit) begin
      // Active prescale only changes when count is 0, so >= is purely
      // defensive against a terminal count lowered below the count.
      count <= 16'd0;
      tick  <= 1'b1;
    end else begin
      count <= count + 16'd1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_um_jimktrains_vslc_servo_ctrl.sv
// Configuration and timing controller for one vslc servo PWM channel.
// Holds shadow and active timing sets, the servo tick prescaler, a mirror of
// the channel's period counter and a commit FSM that swaps shadow into
// active atomically on a period wrap, so the channel never sees a partly
// updated timing set.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_valid/ready   write handshake
//   cfg_addr/data     register address and write data
//   servo_clk         one-cycle tick to the channel
//   servo_set_val     active set compare
//   servo_reset_val   active reset compare
//   servo_freq_val    active period terminal count
//   servo_enabled     channel enable
//   commit_pending    commit FSM state (high = waiting for period wrap)
//   period_start      one-cycle pulse at the start of each period
//
// Handshake: a write transfers on a clock edge where cfg_valid && cfg_ready.
// cfg_ready is low exactly while a commit is pending; the master must hold
// its write until it is accepted, nothing is ever dropped or queued.
module tt_um_jimktrains_vslc_servo_ctrl
  import vslc_servo_pkg::*;
#(
  parameter logic [7:0]  DEF_SET      = 8'd100,
  parameter logic [7:0]  DEF_RESET    = 8'd200,
  parameter logic [15:0] DEF_FREQ     = 16'd1999,
  parameter logic [15:0] DEF_PRESCALE = 16'd99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic        servo_clk,
  output logic [7:0]  servo_set_val,
  output logic [7:0]  servo_reset_val,
  output logic [15:0] servo_freq_val,
  output logic        servo_enabled,
  output logic        commit_pending,
  output logic        period_start
);

  localparam timing_t DEF_TIMING = '{
    set_val:   DEF_SET,
    reset_val: DEF_RESET,
    freq:      DEF_FREQ,
    prescale:  DEF_PRESCALE
  };

  timing_t       active_q;
  timing_t       shadow_q;
  logic          enabled_q;
  commit_state_e state_q;
  commit_state_e state_d;
  logic [15:0]   mirror_q;
  logic          period_start_q;
  logic          tick;

  logic accept;
  logic ctrl_wr;
  logic disable_wr;
  logic enable_wr;
  logic commit_req;
  logic wrap;
  logic commit_now;

  assign cfg_ready  = (state_q == COMMIT_IDLE);
  assign accept     = cfg_valid && cfg_ready;
  assign ctrl_wr    = accept && (cfg_addr == ADDR_CTRL);
  assign disable_wr = ctrl_wr && !cfg_data[CTRL_ENABLE];
  assign enable_wr  = ctrl_wr && cfg_data[CTRL_ENABLE] && !enabled_q;
  assign commit_req = ctrl_wr && cfg_data[CTRL_ENABLE] && cfg_data[CTRL_COMMIT]
                      && enabled_q;
  // Wrap tick: the channel sees its last tick of the period with the
  // current (old) timing set; anything committed here applies from the
  // next tick on.
  assign wrap       = enabled_q && tick && (mirror_q == active_q.freq);

  vslc_servo_prescaler u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (enabled_q),
    .clear    (disable_wr),
    .prescale (active_q.prescale),
    .tick     (tick)
  );

  // Commit FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COMMIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    commit_now = 1'b0;
    case (state_q)
      COMMIT_IDLE: begin
        if (commit_req) begin
          state_d = COMMIT_PENDING;
        end
      end
      COMMIT_PENDING: begin
        if (wrap) begin
          state_d    = COMMIT_IDLE;
          commit_now = 1'b1;
        end
      end
      default: state_d = COMMIT_IDLE;
    endcase
    // Disabling always commits immediately and abandons any pending swap.
    if (disable_wr) begin
      state_d    = COMMIT_IDLE;
      commit_now = 1'b0;
    end
  end

  // Shadow, active and enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= DEF_TIMING;
      active_q  <= DEF_TIMING;
      enabled_q <= 1'b0;
    end else begin
      if (accept) begin
        shadow_q <= apply_write(shadow_q, cfg_addr, cfg_data);
      end
      if (disable_wr || enable_wr || commit_now) begin
        active_q <= shadow_q;
      end
      if (disable_wr) begin
        enabled_q <= 1'b0;
      end else if (enable_wr) begin
        enabled_q <= 1'b1;
      end
    end
  end

  // Mirror of the channel's period counter and period_start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mirror_q       <= 16'd0;
      period_start_q <= 1'b0;
    end else if (disable_wr || !enabled_q) begin
      mirror_q       <= 16'd0;
      // Enabling starts a fresh period right away.
      period_start_q <= enable_wr;
    end else if (tick) begin
      if (mirror_q == active_q.freq) begin
        mirror_q       <= 16'd0;
        period_start_q <= 1'b1;
      end else begin
        mirror_q       <= mirror_q + 16'd1;
        period_start_q <= 1'b0;
      end
    end else begin
      period_start_q <= 1'b0;
    end
  end

  assign servo_clk       = tick;
  assign servo_set_val   = active_q.set_val;
  assign servo_reset_val = active_q.reset_val;
  assign servo_freq_val  = active_q.freq;
  assign servo_enabled   = enabled_q;
  assign commit_pending  = (state_q == COMMIT_PENDING);
  assign period_start    = period_start_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_servo_ctrl.sv
// Bench for tt_um_jimktrains_vslc_servo_ctrl: directed scenarios plus a
// randomized phase, with every cycle compared against a behavioural model.
module tb_tt_um_jimktrains_vslc_servo_ctrl;

  localparam logic [7:0]  DEF_SET      = 8'd100;
  localparam logic [7:0]  DEF_RESET    = 8'd200;
  localparam logic [15:0] DEF_FREQ     = 16'd1999;
  localparam logic [15:0] DEF_PRESCALE = 16'd99;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_addr = 3'd0;
  logic [7:0]  cfg_data = 8'd0;
  logic        servo_clk;
  logic [7:0]  servo_set_val;
  logic [7:0]  servo_reset_val;
  logic [15:0] servo_freq_val;
  logic        servo_enabled;
  logic        commit_pending;
  logic        period_start;

  always #5 clk = ~clk;

  tt_um_jimktrains_vslc_servo_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .servo_clk       (servo_clk),
    .servo_set_val   (servo_set_val),
    .servo_reset_val (servo_reset_val),
    .servo_freq_val  (servo_freq_val),
    .servo_enabled   (servo_enabled),
    .commit_pending  (commit_pending),
    .period_start    (period_start)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- behavioural model ----------------
  // Model state describes the current cycle. m_to_tick counts cycles until
  // the next servo tick; m_pos is how many ticks of the period have passed.
  logic        m_en, m_pend, m_pstart;
  logic [7:0]  ma_set, ma_rst, ms_set, ms_rst;
  logic [15:0] ma_freq, ma_pre, ms_freq, ms_pre;
  int          m_to_tick, m_pos;

  function automatic int p_of(input logic [15:0] pre);
    return (pre == 16'd0) ? 1 : int'(pre);
  endfunction

  function automatic logic m_tick();
    return m_en && (m_to_tick == 0);
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_pend = 1'b0; m_pstart = 1'b0;
    ma_set = DEF_SET; ma_rst = DEF_RESET; ma_freq = DEF_FREQ; ma_pre = DEF_PRESCALE;
    ms_set = DEF_SET; ms_rst = DEF_RESET; ms_freq = DEF_FREQ; ms_pre = DEF_PRESCALE;
    m_to_tick = 0; m_pos = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] a,
                            input logic [7:0] d, output logic acc);
    logic tick_now, wrap_now, n_en, n_pend, n_pstart;
    logic [7:0] n_set, n_rst;
    logic [15:0] n_freq, n_pre;
    int n_to, n_pos;
    acc      = v && !m_pend;
    tick_now = m_tick();
    wrap_now = tick_now && (m_pos == int'(ma_freq));
    n_en = m_en; n_pend = m_pend; n_pstart = 1'b0;
    n_set = ma_set; n_rst = ma_rst; n_freq = ma_freq; n_pre = ma_pre;
    n_to = m_to_tick; n_pos = m_pos;
    if (acc && a == 3'd6 && !d[0]) begin
      n_en = 1'b0; n_pend = 1'b0;
      n_set = ms_set; n_rst = ms_rst; n_freq = ms_freq; n_pre = ms_pre;
      n_pos = 0;
    end else if (acc && a == 3'd6 && !m_en) begin
      n_en = 1'b1; n_pend = 1'b0; n_pstart = 1'b1;
      n_set = ms_set; n_rst = ms_rst; n_freq = ms_freq; n_pre = ms_pre;
      n_pos = 0;
      n_to = p_of(ms_pre) + 1;
    end else if (m_en) begin
      if (tick_now) begin
        n_pos    = wrap_now ? 0 : m_pos + 1;
        n_pstart = wrap_now;
        if (wrap_now && m_pend) begin
          n_set = ms_set; n_rst = ms_rst; n_freq = ms_freq; n_pre = ms_pre;
          n_pend = 1'b0;
        end
        n_to = p_of(n_pre);
      end else begin
        n_to = m_to_tick - 1;
      end
      if (acc && a == 3'd6 && d[1]) n_pend = 1'b1;
    end
    if (acc) begin
      case (a)
        3'd0: ms_set = d;
        3'd1: ms_rst = d;
        3'd2: ms_freq[7:0] = d;
        3'd3: ms_freq[15:8] = d;
        3'd4: ms_pre[7:0] = d;
        3'd5: ms_pre[15:8] = d;
        default: ;
      endcase
    end
    m_en = n_en; m_pend = n_pend; m_pstart = n_pstart;
    ma_set = n_set; ma_rst = n_rst; ma_freq = n_freq; ma_pre = n_pre;
    m_to_tick = n_to; m_pos = n_pos;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("servo_clk",       32'(servo_clk),       32'(m_tick()));
    chk("servo_set_val",   32'(servo_set_val),   32'(ma_set));
    chk("servo_reset_val", 32'(servo_reset_val), 32'(ma_rst));
    chk("servo_freq_val",  32'(servo_freq_val),  32'(ma_freq));
    chk("servo_enabled",   32'(servo_enabled),   32'(m_en));
    chk("commit_pending",  32'(commit_pending),  32'(m_pend));
    chk("period_start",    32'(period_start),    32'(m_pstart));
    chk("cfg_ready",       32'(cfg_ready),       32'(!m_pend));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: drive inputs, advance the model over
  // the next rising edge, then compare at the following falling edge.
  task automatic cycle(input logic v, input logic [2:0] a, input logic [7:0] d,
                       output logic acc);
    cfg_valid = v; cfg_addr = a; cfg_data = d;
    model_step(v, a, d, acc);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'd0, acc);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cycle(1'b1, a, d, acc);
    cfg_valid = 1'b0;
    if (!acc) chk("write_accept_timeout", 32'(acc), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int first, second, cnt, b2b;
    logic prev, acc, found;
    model_reset();
    #1;
    chk("async_reset_servo_clk", 32'(servo_clk), 32'd0);
    chk("async_reset_ready",     32'(cfg_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Reset values pinned against literals
    chk("rst_set",     32'(servo_set_val),   32'd100);
    chk("rst_reset",   32'(servo_reset_val), 32'd200);
    chk("rst_freq",    32'(servo_freq_val),  32'd1999);
    chk("rst_enabled", 32'(servo_enabled),   32'd0);

    // Enable with defaults: one tick every 100 clocks
    write_reg(3'd6, 8'h01);
    chk("en_period_start", 32'(period_start),  32'd1);
    chk("en_enabled",      32'(servo_enabled), 32'd1);
    first = 0; second = 0;
    for (int k = 1; k <= 250 && second == 0; k++) begin
      idle(1);
      if (servo_clk) begin
        if (first == 0) first = k;
        else second = k;
      end
    end
    chk("first_tick_delay", 32'(first), 32'd100);
    chk("tick_interval",    32'(second - first), 32'd100);
    chk("def_freq_active",  32'(servo_freq_val), 32'd1999);

    // prescale 0 -> tick every 2nd clock, never back to back
    write_reg(3'd6, 8'h00);
    write_reg(3'd4, 8'd0);
    write_reg(3'd2, 8'd9);
    write_reg(3'd3, 8'd0);
    write_reg(3'd6, 8'h01);
    cnt = 0; b2b = 0; prev = 1'b0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (servo_clk) cnt++;
      if (servo_clk && prev) b2b++;
      prev = servo_clk;
    end
    chk("pre0_ticks_in_20", 32'(cnt), 32'd10);
    chk("pre0_back_to_back", 32'(b2b), 32'd0);

    // Pending commit swaps on the wrap tick of the old period
    write_reg(3'd0, 8'd3);
    write_reg(3'd2, 8'd4);
    write_reg(3'd6, 8'h03);
    chk("commit_pending_set", 32'(commit_pending), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (commit_pending) begin
        chk("old_freq_held", 32'(servo_freq_val), 32'd9);
        chk("ready_low_pending", 32'(cfg_ready), 32'd0);
      end
      idle(1);
      found = !commit_pending;
    end
    chk("commit_done", 32'(found), 32'd1);
    chk("new_freq",      32'(servo_freq_val), 32'd4);
    chk("new_set",       32'(servo_set_val),  32'd3);
    chk("commit_pstart", 32'(period_start),   32'd1);
    cnt = 0; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      idle(1);
      if (servo_clk) cnt++;
      found = period_start;
    end
    chk("ticks_per_period_freq4", 32'(cnt), 32'd5);

    // Write held while pending, accepted after commit; then disable commits
    write_reg(3'd1, 8'd150);
    write_reg(3'd6, 8'h03);
    write_reg(3'd0, 8'd77);
    chk("held_set_active", 32'(servo_set_val),   32'd3);
    chk("held_reset_cmt",  32'(servo_reset_val), 32'd150);
    chk("held_not_pend",   32'(commit_pending),  32'd0);
    write_reg(3'd6, 8'h00);
    chk("dis_enabled", 32'(servo_enabled), 32'd0);
    chk("dis_set",     32'(servo_set_val), 32'd77);
    chk("dis_clk",     32'(servo_clk),     32'd0);

    // Asynchronous reset in the middle of a pending commit, on a tick cycle
    write_reg(3'd2, 8'd9);
    write_reg(3'd6, 8'h01);
    write_reg(3'd0, 8'd20);
    write_reg(3'd6, 8'h03);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      found = m_pend && m_tick();
      if (!found) idle(1);
    end
    chk("reach_pending_tick", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_set",     32'(servo_set_val),   32'd100);
    chk("arst_reset",   32'(servo_reset_val), 32'd200);
    chk("arst_freq",    32'(servo_freq_val),  32'd1999);
    chk("arst_enabled", 32'(servo_enabled),   32'd0);
    chk("arst_pending", 32'(commit_pending),  32'd0);
    chk("arst_clk",     32'(servo_clk),       32'd0);
    chk("arst_ready",   32'(cfg_ready),       32'd1);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Randomized phase with short periods
    write_reg(3'd4, 8'd1);
    write_reg(3'd5, 8'd0);
    write_reg(3'd2, 8'd3);
    write_reg(3'd3, 8'd0);
    write_reg(3'd6, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic [2:0] a;
      logic [7:0] d;
      v = ($urandom_range(0, 1) == 1);
      a = 3'($urandom_range(0, 7));
      case (a)
        3'd2:       d = 8'($urandom_range(0, 7));
        3'd3, 3'd5: d = 8'd0;
        3'd4:       d = 8'($urandom_range(0, 3));
        3'd6: begin
          d = 8'($urandom_range(0, 255));
          d[0] = ($urandom_range(0, 7) != 0);
        end
        default:    d = 8'($urandom_range(0, 255));
      endcase
      cycle(v, a, d, acc);
    end
    cfg_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
